// File: rtl/dac_interface.sv
// dac_interface: SI-handshake sample sink driving a parallel DAC through a small FIFO.
// Build macro DAC_TEST_PATTERN_EN: drive the DAC bus from an internal ramp instead of FIFO data.
module dac_interface #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CLK_DIV_WIDTH = 32,
  parameter int unsigned FIFO_AW       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    SI_data,
  input  logic                     SI_rdy,
  output logic                     SI_ack,
  input  logic                     enable,
  input  logic [CLK_DIV_WIDTH-1:0] decimation_factor,
  output logic [DATA_WIDTH-1:0]    DAC_data,
  output logic                     DAC_clk,
  output logic                     DAC_pd,
  output logic [15:0]              underrun_count,
  output logic [FIFO_AW:0]         fifo_level
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t state;

  // Divider and strobe
  logic [CLK_DIV_WIDTH-1:0] div_cnt;
  logic [CLK_DIV_WIDTH-1:0] div_last;
  logic                     clk_div;
  logic                     div_zero;
  logic                     div_hit;
  logic                     strobe;

  assign div_zero = (decimation_factor == '0);
  assign div_last = decimation_factor - CLK_DIV_WIDTH'(1);
  // >= rather than == so a lowered divisor mid-count clears instead of wrapping
  assign div_hit  = !div_zero && (div_cnt >= div_last);
  assign strobe   = div_zero || (div_hit && clk_div);
  assign DAC_clk  = div_zero ? clk_i : clk_div;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      div_cnt <= '0;
      clk_div <= 1'b0;
    end else if (!div_zero) begin
      if (div_hit) begin
        div_cnt <= '0;
        clk_div <= ~clk_div;
      end else begin
        div_cnt <= div_cnt + CLK_DIV_WIDTH'(1);
      end
    end
  end

  // FIFO
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign fifo_full  = (fifo_level == FULL_LVL);
  assign fifo_empty = (fifo_level == '0);
  assign SI_ack     = !rst && enable && !fifo_full;
  assign push       = SI_rdy && SI_ack;
  assign pop        = (state == ST_RUN) && enable && strobe && !fifo_empty;

  // Dropping enable flushes in every state; SI_ack is low then, so no push is lost.
  always_ff @(posedge clk_i) begin
    if (rst || !enable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifndef DAC_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= SI_data;
  end
`else
  logic [DATA_WIDTH-1:0] ramp;
`endif

  // Control FSM with registered DAC outputs
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state          <= ST_IDLE;
      DAC_data       <= MIDSCALE;
      DAC_pd         <= 1'b1;
      underrun_count <= '0;
`ifdef DAC_TEST_PATTERN_EN
      ramp           <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          DAC_pd   <= 1'b1;
          DAC_data <= MIDSCALE;
`ifdef DAC_TEST_PATTERN_EN
          ramp     <= '0;
`endif
          if (enable) state <= ST_PRIME;
        end
        ST_PRIME: begin
          if (!enable) begin
            state    <= ST_IDLE;
            DAC_pd   <= 1'b1;
            DAC_data <= MIDSCALE;
          end else begin
            DAC_pd <= 1'b0;
            if (fifo_level >= PRIME_LVL) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state    <= ST_IDLE;
            DAC_pd   <= 1'b1;
            DAC_data <= MIDSCALE;
          end else if (strobe) begin
`ifdef DAC_TEST_PATTERN_EN
            DAC_data <= ramp;
            ramp     <= ramp + DATA_WIDTH'(1);
`else
            if (!fifo_empty) DAC_data <= mem[rd_ptr];
`endif
            if (fifo_empty && (underrun_count != '1))
              underrun_count <= underrun_count + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_interface.sv
// Self-checking bench for dac_interface: scoreboard of accepted SI words against DAC bus updates.
// Build macro DAC_TEST_PATTERN_EN selects the ramp check in place of the data-path scenarios.
module tb_dac_interface;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [7:0]  SI_data;
  logic        SI_rdy;
  logic        SI_ack;
  logic        enable;
  logic [31:0] decimation_factor;
  logic [7:0]  DAC_data;
  logic        DAC_clk;
  logic        DAC_pd;
  logic [15:0] underrun_count;
  logic [2:0]  fifo_level;

  always #5 clk_i = ~clk_i;

  dac_interface #(
    .DATA_WIDTH(8),
    .CLK_DIV_WIDTH(32),
    .FIFO_AW(2)
  ) dut (
    .clk_i(clk_i),
    .rst(rst),
    .SI_data(SI_data),
    .SI_rdy(SI_rdy),
    .SI_ack(SI_ack),
    .enable(enable),
    .decimation_factor(decimation_factor),
    .DAC_data(DAC_data),
    .DAC_clk(DAC_clk),
    .DAC_pd(DAC_pd),
    .underrun_count(underrun_count),
    .fifo_level(fifo_level)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit         fell_q[$];
  logic       prev_clk = 1'b0;
  logic       cur_clk = 1'b0;
  logic       neg_dac_clk = 1'b0;
  logic       prev_pd = 1'b1;
  logic [7:0] prev_data = 8'h80;

  // One clk_i cycle: record accepted words before the edge, DAC bus updates after it.
  task automatic tick();
    @(negedge clk_i);
    #1;
    neg_dac_clk = DAC_clk;
    if (SI_rdy && SI_ack) exp_q.push_back(SI_data);
    @(posedge clk_i);
    #1;
    prev_clk = cur_clk;
    cur_clk  = DAC_clk;
    if (!DAC_pd && !prev_pd && (DAC_data !== prev_data)) begin
      obs_q.push_back(DAC_data);
      fell_q.push_back(prev_clk && !cur_clk);
    end
    prev_pd   = DAC_pd;
    prev_data = DAC_data;
  endtask

  task automatic push_word(input logic [7:0] w, input int budget, output bit ok);
    int n0;
    SI_data = w;
    SI_rdy  = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      n0 = exp_q.size();
      tick();
      if (exp_q.size() > n0) ok = 1'b1;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    fell_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; SI_rdy = 1'b1; SI_data = 8'h5A; decimation_factor = 32'd2;
    repeat (3) tick();
    checks++; if (SI_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %0b expected 0", SI_ack); end
    checks++; if (DAC_data !== 8'h80) begin errors++; $display("FAIL rst_data: got %0h expected 80", DAC_data); end
    checks++; if (DAC_pd !== 1'b1) begin errors++; $display("FAIL rst_pd: got %0b expected 1", DAC_pd); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL rst_underrun: got %0d expected 0", underrun_count); end
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (SI_ack !== 1'b0) begin errors++; $display("FAIL idle_ack: got %0b expected 0", SI_ack); end
    checks++; if (DAC_data !== 8'h80) begin errors++; $display("FAIL idle_data: got %0h expected 80", DAC_data); end
    checks++; if (DAC_pd !== 1'b1) begin errors++; $display("FAIL idle_pd: got %0b expected 1", DAC_pd); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL idle_level: got %0d expected 0", fifo_level); end
    SI_rdy = 1'b0;
    clear_sb();
  endtask

`ifndef DAC_TEST_PATTERN_EN
  task automatic test_stream();
    bit         ok;
    int         n;
    int         rises[$];
    logic [7:0] d, e;
    logic [7:0] words[3] = '{8'h20, 8'h30, 8'h40};
    bit         f;
    clear_sb();
    decimation_factor = 32'd2;
    enable = 1'b1;
    push_word(8'h10, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_accept0: got no accept expected accept"); end
    SI_rdy = 1'b0;
    repeat (20) tick();
    // A single word is below the priming threshold, so nothing may leave the FIFO.
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL prime_hold_level: got %0d expected 1", fifo_level); end
    checks++; if (DAC_data !== 8'h80 || DAC_pd !== 1'b0) begin errors++; $display("FAIL prime_hold_out: got data %0h pd %0b expected 80 0", DAC_data, DAC_pd); end
    foreach (words[i]) begin
      push_word(words[i], 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stream_accept: got no accept expected accept of %0h", words[i]); end
    end
    SI_rdy = 1'b0;
    n = 0;
    while (obs_q.size() < 4 && n < 100) begin
      tick();
      n++;
      if (!prev_clk && cur_clk) rises.push_back(n);
    end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL stream_timeout: got %0d words expected 4", obs_q.size()); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL stream_underrun: got %0d expected 0", underrun_count); end
    enable = 1'b0;
    checks++; if (rises.size() < 2) begin errors++; $display("FAIL dac_clk_rises: got %0d expected >=2", rises.size()); end
    for (int i = 1; i < rises.size(); i++) begin
      checks++; if (rises[i] - rises[i-1] != 4) begin errors++; $display("FAIL dac_clk_period: got %0d expected 4", rises[i] - rises[i-1]); end
    end
    while (obs_q.size() > 0) begin
      d = obs_q.pop_front();
      f = fell_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL stream_data: got %0h expected nothing", d); end
      else begin
        e = exp_q.pop_front();
        if (d !== e) begin errors++; $display("FAIL stream_data: got %0h expected %0h", d, e); end
      end
      checks++; if (f !== 1'b1) begin errors++; $display("FAIL stream_edge: got falling=%0b expected 1", f); end
    end
    repeat (2) tick();
    checks++; if (DAC_data !== 8'h80 || DAC_pd !== 1'b1 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL stream_disable: got data %0h pd %0b level %0d expected 80 1 0", DAC_data, DAC_pd, fifo_level);
    end
    clear_sb();
  endtask

  task automatic test_n0_underrun();
    bit         ok;
    int         n;
    logic [7:0] d, e;
    decimation_factor = 32'd0;
    enable = 1'b1;
    push_word(8'h55, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL n0_accept: got no accept expected accept of 55"); end
    push_word(8'hAA, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL n0_accept: got no accept expected accept of aa"); end
    SI_rdy = 1'b0;
    n = 0;
    while (obs_q.size() < 2 && n < 20) begin tick(); n++; end
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL n0_timeout: got %0d words expected 2", obs_q.size()); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (underrun_count !== 16'(k) || DAC_data !== 8'hAA) begin
        errors++; $display("FAIL n0_underrun: got count %0d data %0h expected %0d aa", underrun_count, DAC_data, k);
      end
    end
    checks++; if (cur_clk !== 1'b1 || neg_dac_clk !== 1'b0) begin
      errors++; $display("FAIL n0_dac_clk: got high=%0b low=%0b expected 1 0", cur_clk, neg_dac_clk);
    end
    enable = 1'b0;
    tick();
    checks++; if (underrun_count !== 16'd10 || DAC_data !== 8'h80 || DAC_pd !== 1'b1 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL n0_disable: got count %0d data %0h pd %0b level %0d expected 10 80 1 0", underrun_count, DAC_data, DAC_pd, fifo_level);
    end
    while (obs_q.size() > 0) begin
      d = obs_q.pop_front();
      void'(fell_q.pop_front());
      checks++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      if (d !== e) begin errors++; $display("FAIL n0_data: got %0h expected %0h", d, e); end
    end
    tick();
    clear_sb();
  endtask

  task automatic test_backpressure();
    bit         ok;
    int         n;
    logic [7:0] d, e;
    decimation_factor = 32'd1000;
    enable = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      push_word(8'(w), 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no accept expected accept of %0d", w); end
    end
    SI_data = 8'h05;
    SI_rdy  = 1'b1;
    repeat (10) tick();
    checks++; if (exp_q.size() != 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", exp_q.size()); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d expected 4", fifo_level); end
    checks++; if (SI_ack !== 1'b0) begin errors++; $display("FAIL bp_ack: got %0b expected 0", SI_ack); end
    decimation_factor = 32'd0;
    push_word(8'h05, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept5: got no accept expected accept"); end
    push_word(8'h06, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept6: got no accept expected accept"); end
    SI_rdy = 1'b0;
    n = 0;
    while (obs_q.size() < 6 && n < 40) begin tick(); n++; end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL bp_words: got %0d expected 6", obs_q.size()); end
    enable = 1'b0;
    for (int i = 1; i <= 6 && obs_q.size() > 0; i++) begin
      d = obs_q.pop_front();
      void'(fell_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (d !== e || d !== 8'(i)) begin errors++; $display("FAIL bp_data: got %0h expected %0h", d, 8'(i)); end
    end
    repeat (2) tick();
    clear_sb();
  endtask
`else
  task automatic test_pattern();
    int         n;
    logic [7:0] d;
    decimation_factor = 32'd0;
    enable  = 1'b1;
    SI_rdy  = 1'b1;
    n = 0;
    while (obs_q.size() < 300 && n < 400) begin
      SI_data = 8'(n);
      tick();
      n++;
    end
    SI_rdy = 1'b0;
    checks++; if (obs_q.size() != 300) begin errors++; $display("FAIL ramp_timeout: got %0d strobes expected 300", obs_q.size()); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL ramp_underrun: got %0d expected 0", underrun_count); end
    for (int i = 0; i < 300 && obs_q.size() > 0; i++) begin
      d = obs_q.pop_front();
      checks++; if (d !== 8'(i % 256)) begin errors++; $display("FAIL ramp_data: got %0h expected %0h", d, 8'(i % 256)); end
    end
    enable = 1'b0;
    repeat (2) tick();
    clear_sb();
  endtask
`endif

  task automatic test_div_change();
    bit found;
    bit toggled;
    enable = 1'b0;
    decimation_factor = 32'd8;
    tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (cur_clk !== prev_clk) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL div8_toggle: got no toggle expected toggle within 40"); end
    toggled = 1'b0;
    repeat (6) begin
      tick();
      if (cur_clk !== prev_clk) toggled = 1'b1;
    end
    checks++; if (toggled) begin errors++; $display("FAIL div8_hold: got toggle expected none for 6 cycles"); end
    decimation_factor = 32'd2;
    tick();
    checks++; if (cur_clk === prev_clk) begin errors++; $display("FAIL div_shrink_clear: got no toggle expected toggle"); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if ((cur_clk !== prev_clk) !== (i % 2 == 0)) begin
        errors++; $display("FAIL div2_period: got toggle=%0b expected %0b at cycle %0d", cur_clk !== prev_clk, i % 2 == 0, i);
      end
    end
    clear_sb();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    decimation_factor = 32'd2;
    enable = 1'b1;
    push_word(8'h11, 10, ok);
    push_word(8'h22, 10, ok);
    push_word(8'h33, 10, ok);
    SI_rdy = 1'b1;
    SI_data = 8'h44;
    n = 0;
    while (obs_q.size() < 1 && n < 40) begin tick(); n++; end
    checks++; if (obs_q.size() < 1) begin errors++; $display("FAIL mid_run_timeout: got no output expected one"); end
    rst = 1'b1;
    #1;
    checks++; if (SI_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: got %0b expected 0", SI_ack); end
    tick();
    SI_rdy = 1'b0;
    checks++; if (DAC_data !== 8'h80 || DAC_pd !== 1'b1 || fifo_level !== 3'd0 || underrun_count !== 16'd0) begin
      errors++; $display("FAIL mid_rst_out: got data %0h pd %0b level %0d count %0d expected 80 1 0 0", DAC_data, DAC_pd, fifo_level, underrun_count);
    end
    rst = 1'b0;
    clear_sb();
    repeat (10) tick();
    checks++; if (fifo_level !== 3'd0 || DAC_data !== 8'h80 || obs_q.size() != 0) begin
      errors++; $display("FAIL mid_rst_flush: got level %0d data %0h outputs %0d expected 0 80 0", fifo_level, DAC_data, obs_q.size());
    end
    enable = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef DAC_TEST_PATTERN_EN
    test_pattern();
`else
    test_stream();
    test_n0_underrun();
    test_backpressure();
`endif
    test_div_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
